// File: rtl/i2c_pad_conditioner.sv
// i2c_pad_conditioner
// Pad-side conditioning between the open-drain SCL/SDA pads and the I2C master:
// two-flop synchronisers, optional per-line glitch filter, registered pad
// enables and a bus monitor (START/STOP, bus-busy with idle timeout, SDA conflict).
// Build option: define I2C_PAD_GLITCH_FILTER_EN to include the glitch filter;
// without it the filtered lines follow the synchronisers directly.
module i2c_pad_conditioner #(
    parameter int FILTER_LEN      = 4,
    parameter int BUS_FREE_CYCLES = 64
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic scl_pad_i,
    input  logic sda_pad_i,
    input  logic scl_oen_i,
    input  logic sda_oen_i,
    output logic scl_i,
    output logic sda_i,
    output logic scl_pad_oe,
    output logic sda_pad_oe,
    output logic bus_busy,
    output logic start_det,
    output logic stop_det,
    output logic sda_conflict
);

    localparam logic [15:0] BUS_FREE_LAST = 16'(BUS_FREE_CYCLES - 1);

    // Out-of-range parameters show up as a named block in the elaborated hierarchy.
    if (FILTER_LEN < 1 || FILTER_LEN > 15 ||
        BUS_FREE_CYCLES < 2 || BUS_FREE_CYCLES > 65535) begin : g_param_out_of_range
    end

    logic scl_meta_p0, sda_meta_p0;
    logic scl_sync_p1, sda_sync_p1;
    logic scl_f, sda_f;
    logic scl_p, sda_p;
    logic armed;
    logic [15:0] free_cnt;
    logic start_hit, stop_hit, conflict_hit, free_hit;

    // ---- stage p0/p1: two-flop synchronisers, idle-high after reset
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            scl_meta_p0 <= 1'b1;
            sda_meta_p0 <= 1'b1;
            scl_sync_p1 <= 1'b1;
            sda_sync_p1 <= 1'b1;
        end else begin
            scl_meta_p0 <= scl_pad_i;
            sda_meta_p0 <= sda_pad_i;
            scl_sync_p1 <= scl_meta_p0;
            sda_sync_p1 <= sda_meta_p0;
        end
    end

`ifdef I2C_PAD_GLITCH_FILTER_EN
    localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

    logic [3:0] scl_cnt, sda_cnt;

    // ---- glitch filter: a level must persist FILTER_LEN cycles before f follows it
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_cnt <= 4'd0;
            sda_cnt <= 4'd0;
        end else begin
            if (scl_sync_p1 != scl_f) begin
                if (scl_cnt == FILT_LAST) begin
                    scl_f   <= scl_sync_p1;
                    scl_cnt <= 4'd0;
                end else begin
                    scl_cnt <= scl_cnt + 4'd1;
                end
            end else begin
                scl_cnt <= 4'd0;
            end

            if (sda_sync_p1 != sda_f) begin
                if (sda_cnt == FILT_LAST) begin
                    sda_f   <= sda_sync_p1;
                    sda_cnt <= 4'd0;
                end else begin
                    sda_cnt <= sda_cnt + 4'd1;
                end
            end else begin
                sda_cnt <= 4'd0;
            end
        end
    end
`else
    // Without the filter the synchronised levels are the filtered levels.
    assign scl_f = scl_sync_p1;
    assign sda_f = sda_sync_p1;
`endif

    assign scl_i = scl_f;
    assign sda_i = sda_f;

    // Bus conditions, all qualified by armed so a bus held low through reset is ignored.
    // Simultaneous SCL/SDA changes fail the scl_p & scl_f term of START/STOP.
    assign start_hit    = armed & scl_p & scl_f & sda_p & ~sda_f;
    assign stop_hit     = armed & scl_p & scl_f & ~sda_p & sda_f;
    assign conflict_hit = armed & ~scl_p & scl_f & sda_oen_i & ~sda_f;
    assign free_hit     = bus_busy & scl_f & sda_f & (free_cnt == BUS_FREE_LAST);

    // ---- monitor stage: edge history, arming, event pulses, bus-busy and idle timer
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            scl_p        <= 1'b1;
            sda_p        <= 1'b1;
            armed        <= 1'b0;
            start_det    <= 1'b0;
            stop_det     <= 1'b0;
            sda_conflict <= 1'b0;
            bus_busy     <= 1'b0;
            free_cnt     <= 16'd0;
        end else begin
            scl_p        <= scl_f;
            sda_p        <= sda_f;
            armed        <= armed | (scl_f & sda_f);
            start_det    <= start_hit;
            stop_det     <= stop_hit;
            sda_conflict <= conflict_hit;

            // START wins so a repeated START never loses ownership to the timer.
            if (start_hit) begin
                bus_busy <= 1'b1;
            end else if (stop_hit || free_hit) begin
                bus_busy <= 1'b0;
            end

            // Idle timer recovers bus_busy after a missed STOP.
            if (scl_f && sda_f && bus_busy && !free_hit) begin
                free_cnt <= free_cnt + 16'd1;
            end else begin
                free_cnt <= 16'd0;
            end
        end
    end

    // ---- output stage: active-low master enables become registered active-high pad enables
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            scl_pad_oe <= 1'b0;
            sda_pad_oe <= 1'b0;
        end else begin
            scl_pad_oe <= ~scl_oen_i;
            sda_pad_oe <= ~sda_oen_i;
        end
    end

endmodule

// File: tb/tb_i2c_pad_conditioner.sv
// Directed, scoreboard-checked bench for i2c_pad_conditioner.
module tb_i2c_pad_conditioner;

    localparam int FILTER_LEN      = 4;
    localparam int BUS_FREE_CYCLES = 64;
`ifdef I2C_PAD_GLITCH_FILTER_EN
    localparam int LAT        = 2 + FILTER_LEN;
    localparam int GLITCH_LOW = 0;
`else
    localparam int LAT        = 2;
    localparam int GLITCH_LOW = 3;
`endif

    logic PCLK;
    logic PRESETn;
    logic scl_pad_i, sda_pad_i, scl_oen_i, sda_oen_i;
    logic scl_i, sda_i, scl_pad_oe, sda_pad_oe;
    logic bus_busy, start_det, stop_det, sda_conflict;

    i2c_pad_conditioner #(
        .FILTER_LEN      (FILTER_LEN),
        .BUS_FREE_CYCLES (BUS_FREE_CYCLES)
    ) dut (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .scl_pad_i    (scl_pad_i),
        .sda_pad_i    (sda_pad_i),
        .scl_oen_i    (scl_oen_i),
        .sda_oen_i    (sda_oen_i),
        .scl_i        (scl_i),
        .sda_i        (sda_i),
        .scl_pad_oe   (scl_pad_oe),
        .sda_pad_oe   (sda_pad_oe),
        .bus_busy     (bus_busy),
        .start_det    (start_det),
        .stop_det     (stop_det),
        .sda_conflict (sda_conflict)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Event counters sampled on the inactive edge.
    int n_start = 0, n_stop = 0, n_conf = 0, n_sda_low = 0;
    always @(negedge PCLK) begin
        if (start_det === 1'b1)    n_start++;
        if (stop_det === 1'b1)     n_stop++;
        if (sda_conflict === 1'b1) n_conf++;
        if (sda_i === 1'b0)        n_sda_low++;
    end

    logic [31:0] exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] want;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %0d, scoreboard empty", tag, obs);
        end else begin
            want = exp_q.pop_front();
            assert (obs === want) else begin
                n_fail++;
                $error("FAIL %s: observed %0d, expected %0d", tag, obs, want);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    int b_start, b_stop, b_conf, b_low;
    task automatic snap();
        b_start = n_start;
        b_stop  = n_stop;
        b_conf  = n_conf;
        b_low   = n_sda_low;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset with the master trying to drive SCL: pad stays released.
        PRESETn = 1'b0; scl_pad_i = 1'b1; sda_pad_i = 1'b1;
        scl_oen_i = 1'b0; sda_oen_i = 1'b1;
        push(0); push(0); push(1); push(1); push(0); push(0); push(0); push(0);
        tick(3);
        check("rst_scl_pad_oe", scl_pad_oe);
        check("rst_sda_pad_oe", sda_pad_oe);
        check("rst_scl_i", scl_i);
        check("rst_sda_i", sda_i);
        check("rst_bus_busy", bus_busy);
        check("rst_start_det", start_det);
        check("rst_stop_det", stop_det);
        check("rst_sda_conflict", sda_conflict);

        // Release with an idle bus: arms, no pulses, oe follows ~oen after 1 cycle.
        snap();
        PRESETn = 1'b1;
        push(1); push(1); push(0); push(0);
        tick(3);
        check("idle_armed", dut.armed);
        check("idle_scl_pad_oe", scl_pad_oe);
        check("idle_no_start", n_start - b_start);
        check("idle_no_stop", n_stop - b_stop);
        scl_oen_i = 1'b1; sda_oen_i = 1'b0;
        push(0); push(1);
        tick(1);
        check("oen_scl_pad_oe", scl_pad_oe);
        check("oen_sda_pad_oe", sda_pad_oe);
        sda_oen_i = 1'b1;
        push(0);
        tick(1);
        check("oen_sda_pad_oe_rel", sda_pad_oe);

        // Glitch handling with SCL low so SDA movement is not a bus condition.
        scl_pad_i = 1'b0;
        push(0);
        tick(LAT + 2);
        check("scl_low_level", scl_i);
        snap();
        sda_pad_i = 1'b0;
        tick(3);
        sda_pad_i = 1'b1;
        push(GLITCH_LOW);
        tick(LAT + 4);
        check("glitch_sda_low_cycles", n_sda_low - b_low);
        sda_pad_i = 1'b0;
        push(1); push(0);
        tick(LAT - 1);
        check("sda_fall_before", sda_i);
        tick(1);
        check("sda_fall_at_lat", sda_i);
        tick(3);
        sda_pad_i = 1'b1;
        tick(LAT + 6);
        scl_pad_i = 1'b1;
        push(0); push(0); push(0); push(1);
        tick(LAT + 2);
        check("glitch_no_start", n_start - b_start);
        check("glitch_no_stop", n_stop - b_stop);
        check("glitch_busy", bus_busy);
        check("glitch_sda_back", sda_i);

        // START then STOP.
        snap();
        sda_pad_i = 1'b0;
        push(0); push(1); push(1); push(1); push(0);
        tick(LAT);
        check("start_busy_before", bus_busy);
        tick(1);
        check("start_busy", bus_busy);
        check("start_det_pulse", start_det);
        tick(3);
        check("start_count", n_start - b_start);
        check("start_det_done", start_det);
        snap();
        sda_pad_i = 1'b1;
        push(1); push(0); push(1); push(1); push(0);
        tick(LAT);
        check("stop_busy_before", bus_busy);
        tick(1);
        check("stop_busy", bus_busy);
        check("stop_det_pulse", stop_det);
        tick(3);
        check("stop_count", n_stop - b_stop);
        check("stop_no_start", n_start - b_start);

        // SCL and SDA change together: neither START nor STOP.
        snap();
        scl_pad_i = 1'b0; sda_pad_i = 1'b0;
        push(0); push(0);
        tick(LAT + 3);
        check("simul_fall_no_start", n_start - b_start);
        check("simul_fall_busy", bus_busy);
        scl_pad_i = 1'b1; sda_pad_i = 1'b1;
        push(0); push(0);
        tick(LAT + 3);
        check("simul_rise_no_stop", n_stop - b_stop);
        check("simul_rise_busy", bus_busy);

        // Timeout: START, then both lines high without a STOP edge.
        sda_pad_i = 1'b0;
        push(1);
        tick(LAT + 2);
        check("to_start_busy", bus_busy);
        scl_pad_i = 1'b0;
        tick(LAT + 1);
        sda_pad_i = 1'b1;
        tick(LAT + 1);
        snap();
        scl_pad_i = 1'b1;
        push(1); push(0); push(0);
        tick(LAT + BUS_FREE_CYCLES - 1);
        check("to_busy_before", bus_busy);
        tick(1);
        check("to_busy_cleared", bus_busy);
        check("to_no_stop", n_stop - b_stop);

        // Same again with a repeated START landing on cycle 63.
        sda_pad_i = 1'b0;
        push(1);
        tick(LAT + 2);
        check("to2_start_busy", bus_busy);
        scl_pad_i = 1'b0;
        tick(LAT + 1);
        sda_pad_i = 1'b1;
        tick(LAT + 1);
        snap();
        scl_pad_i = 1'b1;
        tick(BUS_FREE_CYCLES - 1);
        sda_pad_i = 1'b0;
        push(1); push(1); push(1); push(1); push(1);
        tick(LAT);
        check("to2_busy_c63", bus_busy);
        tick(1);
        check("to2_busy_c64", bus_busy);
        check("to2_start_det", start_det);
        tick(10);
        check("to2_busy_held", bus_busy);
        check("to2_start_count", n_start - b_start);
        sda_pad_i = 1'b1;
        push(0);
        tick(LAT + 3);
        check("to2_stop_busy", bus_busy);

        // Conflict: SDA released but reads 0 on SCL rising.
        scl_pad_i = 1'b0;
        tick(LAT + 1);
        sda_oen_i = 1'b1; sda_pad_i = 1'b0;
        tick(LAT + 1);
        snap();
        scl_pad_i = 1'b1;
        push(0); push(1); push(1); push(0);
        tick(LAT);
        check("conf_before", sda_conflict);
        tick(1);
        check("conf_pulse", sda_conflict);
        tick(3);
        check("conf_count", n_conf - b_conf);
        check("conf_no_start", n_start - b_start);
        scl_pad_i = 1'b0;
        tick(LAT + 1);
        sda_oen_i = 1'b0;
        tick(2);
        snap();
        scl_pad_i = 1'b1;
        push(0); push(1);
        tick(LAT + 3);
        check("conf_driven_none", n_conf - b_conf);
        check("conf_driven_sda_pad_oe", sda_pad_oe);

        // Reset asserted mid-transfer clears everything asynchronously.
        scl_pad_i = 1'b0;
        tick(LAT + 1);
        sda_oen_i = 1'b1; sda_pad_i = 1'b1;
        tick(LAT + 1);
        scl_pad_i = 1'b1; scl_oen_i = 1'b0;
        tick(LAT + 2);
        sda_pad_i = 1'b0;
        push(1); push(1);
        tick(LAT + 2);
        check("mid_busy", bus_busy);
        check("mid_scl_pad_oe", scl_pad_oe);
        #3;
        PRESETn = 1'b0;
        push(0); push(0); push(1); push(0);
        #1;
        check("async_busy", bus_busy);
        check("async_scl_pad_oe", scl_pad_oe);
        check("async_sda_i", sda_i);
        check("async_armed", dut.armed);
        tick(2);
        PRESETn = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_pad_conditioner.md
# i2c_pad_conditioner

Pad-side conditioning stage between the I2C SCL/SDA open-drain pads and the I2C master controller.
- Input path: synchronises the raw pad inputs, rejects glitches, and feeds clean `scl_i`/`sda_i` to the master.
- Output path: registers the master's active-low output enables into active-high pad enables.
- Bus monitor: detects START/STOP, tracks bus-busy, and flags SDA conflicts for software and for the interrupt logic.

## Interface
- `FILTER_LEN`, 4: consecutive post-sync cycles a level must hold before the filtered line follows it; legal 1..15.
- `BUS_FREE_CYCLES`, 64: consecutive cycles with both filtered lines high that force `bus_busy` low; legal 2..65535.

- `PCLK` in 1: system clock.
- `PRESETn` in 1: asynchronous, active-low reset.
- `scl_pad_i` in 1: raw SCL pad input.
- `sda_pad_i` in 1: raw SDA pad input.
- `scl_oen_i` in 1: master SCL output enable, active low.
- `sda_oen_i` in 1: master SDA output enable, active low.
- `scl_i` out 1: conditioned SCL to master.
- `sda_i` out 1: conditioned SDA to master.
- `scl_pad_oe` out 1: SCL pad driver enable, active high; pad data is tied 0 externally.
- `sda_pad_oe` out 1: SDA pad driver enable, active high.
- `bus_busy` out 1: bus owned by some master.
- `start_det` out 1: one-cycle pulse on START or repeated START.
- `stop_det` out 1: one-cycle pulse on STOP.
- `sda_conflict` out 1: one-cycle pulse, SDA read 0 while this master released it.

## Operation
- **Synchroniser**
  - Two flops per line, reset to 1.
  - `sync` is the second flop.
- **Glitch filter (per line)**
  - Holds filtered output `f` (reset 1) and counter `cnt` (width 4, reset 0).
  - If `sync != f`: `cnt` increments. When `cnt == FILTER_LEN-1`, `f <= sync` and `cnt <= 0` instead.
  - If `sync == f`: `cnt <= 0`.
  - Mismatches shorter than `FILTER_LEN` consecutive cycles are discarded.
- **Edge history**
  - `scl_p`/`sda_p` are the previous-cycle values of `f`, reset 1.
  - `scl_i = scl_f`, `sda_i = sda_f`.
- **Arming**
  - `armed` (reset 0) sets the first cycle where `scl_f & sda_f`.
  - Every detector output is gated by `armed`. A bus held low through reset release therefore cannot fake START/STOP.
- **START**: `armed & scl_p & scl_f & sda_p & ~sda_f` → `start_det` = 1 for the next cycle, and `bus_busy` is set.
- **STOP**: `armed & scl_p & scl_f & ~sda_p & sda_f` → `stop_det` = 1 for the next cycle, and `bus_busy` is cleared.
- **SCL and SDA changing in the same cycle**: neither START nor STOP is reported.
- **Bus-free timer**
  - 16-bit counter, reset 0.
  - Increments while `scl_f & sda_f & bus_busy`; clears otherwise.
  - Reaching `BUS_FREE_CYCLES-1` clears `bus_busy` and the counter. This recovers from a missed STOP.
  - START in the same cycle takes priority: `bus_busy` stays 1.
- **Conflict**
  - Condition: `armed & ~scl_p & scl_f & sda_oen_i & ~sda_f`, i.e. on the SCL rising edge with SDA released but reading 0.
  - Result: `sda_conflict` pulses for one cycle.
- **Pad enables**: `scl_pad_oe <= ~scl_oen_i`, `sda_pad_oe <= ~sda_oen_i`. Both are registered and reset 0, so the bus is released during reset.
- **Reset asserted mid-transfer**: every output returns to its reset value immediately (asynchronously); the filter counters and `armed` clear.

## Timing
- Reset values:
  - `scl_i` = 1, `sda_i` = 1.
  - `scl_pad_oe` = 0, `sda_pad_oe` = 0.
  - `bus_busy`, `start_det`, `stop_det`, `sda_conflict` = 0.
- Pad-to-`scl_i`/`sda_i` latency is `2+FILTER_LEN` PCLK edges for a persistent level change. Default: 6.
- `start_det`/`stop_det`/`sda_conflict` assert 1 cycle after the qualifying filtered edge. `bus_busy` updates on that same edge as the pulse.
- `oen` to `pad_oe` latency: 1 cycle.
- Release of `bus_busy` through the timer: `BUS_FREE_CYCLES` cycles after both lines become high while busy.

## Configuration
- `I2C_PAD_GLITCH_FILTER_EN`
  - Defined: the glitch filter is as described above.
  - Undefined:
    - The filter stage and `FILTER_LEN` logic are removed; `f = sync`.
    - Pad-to-output latency is 2 cycles.
    - Single-cycle post-sync glitches propagate.
    - All detector, timer and conflict behaviour is otherwise identical.

## Test plan
- **Reset/idle**: with `PRESETn` low, force `scl_oen_i` = 0 → `scl_pad_oe` = 0. Release reset with pads high → `armed` = 1 and no pulses.
- **Glitch**: `FILTER_LEN`=4, `sda_pad_i` low for 3 cycles → `sda_i` stays 1. Low for 4 cycles → `sda_i` falls 6 edges after the pad change.
- **START/STOP**: SCL high, SDA 1→0 → one `start_det` pulse and `bus_busy` = 1. Later SDA 0→1 with SCL high → one `stop_det` pulse and `bus_busy` = 0.
- **Simultaneous**: SCL and SDA fall on the same edge → no `start_det`; `bus_busy` unchanged.
- **Timeout**: after START, hold both lines high without a valid STOP edge for 64 cycles → `bus_busy` clears on cycle 64. Repeat with a START at cycle 63 → `bus_busy` stays 1.
- **Conflict**: `sda_oen_i`=1, `sda_pad_i`=0, SCL rising → one `sda_conflict` pulse. Same stimulus with `sda_oen_i`=0 → no pulse.
